// File: rtl/dpram_adapter_pkg.sv
// -----------------------------------------------------------------------------
// dpram_adapter_pkg
// Shared types for the dual-port RAM request adapter and its response FIFO.
//   WORD_BYTES  : bytes per RAM word (byte address -> word address shift)
//   rsp_entry_t : one queued response {rdata, err}
//   inflight_t  : response owed for the request accepted in the previous cycle
// -----------------------------------------------------------------------------
package dpram_adapter_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_entry_t;

    typedef struct packed {
        logic valid;
        logic is_read;
        logic err;
    } inflight_t;

endpackage

// File: rtl/dpram_rsp_fifo.sv
// -----------------------------------------------------------------------------
// dpram_rsp_fifo
// Synchronous Depth x rsp_entry_t FIFO holding responses the requester has
// not yet taken.
//   clk_i, rst_ni : clock, asynchronous active-low reset (pointers/count)
//   push_i/data_i : write one entry at the tail
//   pop_i/data_o  : data_o is the head; pop_i removes it
//   count_o       : number of stored entries
//   empty_o/full_o: status flags
// -----------------------------------------------------------------------------
module dpram_rsp_fifo
    import dpram_adapter_pkg::*;
#(
    parameter  int unsigned Depth = 2,
    localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  rsp_entry_t      data_i,
    input  logic            pop_i,
    output rsp_entry_t      data_o,
    output logic [CntW-1:0] count_o,
    output logic            empty_o,
    output logic            full_o
);

    rsp_entry_t       r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;

    // Entry storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_wr_ptr <= (r_wr_ptr == PtrW'(Depth - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (pop_i) begin
                r_rd_ptr <= (r_rd_ptr == PtrW'(Depth - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;
    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == CntW'(Depth));

endmodule

// File: rtl/dpram_req_adapter.sv
// -----------------------------------------------------------------------------
// dpram_req_adapter
// Valid/ready request/response front end for one port of the 32-bit dual-port
// RAM. Byte addresses become word addresses; the registered RAM read data is
// returned one cycle after accept, either bypassed straight to the requester
// or parked in a small response FIFO when the requester back-pressures.
//   clk_i, rst_ni                : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o      : request handshake
//   req_addr_i/we/wdata/be       : byte address, write flag, data, byte enables
//   rsp_valid_o/rsp_ready_i      : response handshake (one per request, in order)
//   rsp_rdata_o/rsp_err_o        : read data (0 for writes/errors), error flag
//   mem_addr/din/be/wren/rden_o  : RAM port controls, combinational from request
//   mem_dout_i                   : RAM read data, valid the cycle after rden
// Build option: define DPRAM_ADAPTER_RANGE_CHECK_EN to flag out-of-range or
// misaligned addresses as error responses that do not touch the RAM.
// -----------------------------------------------------------------------------
module dpram_req_adapter
    import dpram_adapter_pkg::*;
#(
    parameter  int unsigned DataWidth     = 32,
    parameter  int unsigned Depth         = 1024,
    parameter  int unsigned AddrWidth     = $clog2(Depth),
    parameter  int unsigned ByteAddrWidth = 32,
    parameter  int unsigned RspDepth      = 2,
    localparam int unsigned CntW          = $clog2(RspDepth + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [ByteAddrWidth-1:0] req_addr_i,
    input  logic                     req_we_i,
    input  logic [DataWidth-1:0]     req_wdata_i,
    input  logic [DataWidth/8-1:0]   req_be_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [DataWidth-1:0]     rsp_rdata_o,
    output logic                     rsp_err_o,
    output logic [AddrWidth-1:0]     mem_addr_o,
    output logic [DataWidth-1:0]     mem_din_o,
    output logic [DataWidth/8-1:0]   mem_be_o,
    output logic                     mem_wren_o,
    output logic                     mem_rden_o,
    input  logic [DataWidth-1:0]     mem_dout_i
);

    inflight_t        r_inflight;
    logic             w_accept;
    logic             w_addr_err;
    logic             w_pop;
    logic             w_fifo_push;
    logic             w_fifo_pop;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic [CntW-1:0]  w_fifo_cnt;
    logic [CntW:0]    w_credit_used;
    rsp_entry_t       w_fifo_head;
    rsp_entry_t       w_bypass_rsp;
    rsp_entry_t       w_rsp;

`ifdef DPRAM_ADAPTER_RANGE_CHECK_EN
    // One extra bit so Depth*4 is representable even when it equals 2**ByteAddrWidth.
    localparam logic [ByteAddrWidth:0] AddrLimit = (ByteAddrWidth + 1)'(Depth * WORD_BYTES);
    assign w_addr_err = ({1'b0, req_addr_i} >= AddrLimit) || (req_addr_i[1:0] != 2'b00);
`else
    logic w_unused_addr;
    assign w_addr_err    = 1'b0;
    assign w_unused_addr = ^req_addr_i;
`endif

    // ---------------- request side ----------------
    // Slots owed after this edge = queued + in flight - leaving now; a new
    // accept may only take a slot that is guaranteed to exist.
    assign w_credit_used = {1'b0, w_fifo_cnt} + (CntW + 1)'(r_inflight.valid)
                         - (CntW + 1)'(w_pop);
    assign req_ready_o   = (w_credit_used < (CntW + 1)'(RspDepth));
    assign w_accept      = req_valid_i & req_ready_o;

    assign mem_addr_o = req_addr_i[AddrWidth+1:2];
    assign mem_din_o  = req_wdata_i;
    assign mem_be_o   = req_be_i;
    assign mem_wren_o = w_accept &  req_we_i & ~w_addr_err;
    assign mem_rden_o = w_accept & ~req_we_i & ~w_addr_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_inflight <= '0;
        end else begin
            r_inflight.valid   <= w_accept;
            r_inflight.is_read <= w_accept & ~req_we_i;
            r_inflight.err     <= w_accept & w_addr_err;
        end
    end

    // ---------------- response side ----------------
    always_comb begin
        w_bypass_rsp       = '0;
        w_bypass_rsp.err   = r_inflight.err;
        w_bypass_rsp.rdata = (r_inflight.is_read && !r_inflight.err) ? 32'(mem_dout_i) : '0;
    end

    // FIFO head has priority so order is kept; the in-flight entry goes straight
    // out only when nothing older is waiting.
    always_comb begin
        w_rsp = '0;
        if (!w_fifo_empty) begin
            w_rsp = w_fifo_head;
        end else if (r_inflight.valid) begin
            w_rsp = w_bypass_rsp;
        end
    end

    assign rsp_valid_o = ~w_fifo_empty | r_inflight.valid;
    assign rsp_rdata_o = DataWidth'(w_rsp.rdata);
    assign w_pop       = rsp_valid_o & rsp_ready_i;
    assign w_fifo_pop  = ~w_fifo_empty & rsp_ready_i;
    // mem_dout_i is not held, so any in-flight response not bypassed-and-taken
    // this cycle must be captured now.
    assign w_fifo_push = r_inflight.valid & ~(w_fifo_empty & rsp_ready_i) & ~w_fifo_full;

`ifdef DPRAM_ADAPTER_RANGE_CHECK_EN
    assign rsp_err_o = w_rsp.err;
`else
    logic w_unused_err;
    assign rsp_err_o    = 1'b0;
    assign w_unused_err = w_rsp.err;
`endif

    dpram_rsp_fifo #(
        .Depth (RspDepth)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_fifo_push),
        .data_i  (w_bypass_rsp),
        .pop_i   (w_fifo_pop),
        .data_o  (w_fifo_head),
        .count_o (w_fifo_cnt),
        .empty_o (w_fifo_empty),
        .full_o  (w_fifo_full)
    );

endmodule
